// File: rtl/axi_strobed_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// axi_strobed_arbiter_pkg
//   Shared types and helpers for the strobed AXI-Stream arbiter.
//   - lock_state_e : packet-lock state (open / held on one channel)
//   - slot_kind_e  : what a strobe slot resolves to in a given cycle
//   - sat_inc16    : saturating 16-bit increment for the underrun counter
//   - wrap_index   : (base + offset) mod modulus for offset <= modulus
// ---------------------------------------------------------------------------
package axi_strobed_arbiter_pkg;

    typedef enum logic {
        LOCK_OPEN = 1'b0,
        LOCK_HELD = 1'b1
    } lock_state_e;

    typedef enum logic [1:0] {
        SLOT_NONE     = 2'd0,  // no slot this cycle (no tick, or held in reset/clear)
        SLOT_IDLE     = 2'd1,  // slot with nothing eligible to send
        SLOT_XFER     = 2'd2,  // slot carries a beat from the granted channel
        SLOT_UNDERRUN = 2'd3   // locked channel had no beat ready mid-packet
    } slot_kind_e;

    localparam logic [15:0] UNDERRUN_MAX = 16'hFFFF;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == UNDERRUN_MAX) ? value : value + 16'd1;
    endfunction

    // Cheap modulo: callers guarantee base < modulus and offset <= modulus,
    // so a single conditional subtract is enough.
    function automatic int wrap_index(input int base, input int offset, input int modulus);
        int sum;
        sum = base + offset;
        return (sum >= modulus) ? sum - modulus : sum;
    endfunction

endpackage

// File: rtl/axi_rr_select.sv
// ---------------------------------------------------------------------------
// axi_rr_select
//   Purely combinational round-robin picker. Searches req_i starting at
//   last_grant_i+1 (wrapping) and returns the first requesting index.
//   Ports:
//     req_i         in  NUM_INPUTS       request vector
//     last_grant_i  in  $clog2(NUM)      most recently granted index
//     grant_valid_o out 1                at least one request present
//     grant_idx_o   out $clog2(NUM)      chosen index (0 when none)
// ---------------------------------------------------------------------------
module axi_rr_select
    import axi_strobed_arbiter_pkg::*;
#(
    parameter int NUM_INPUTS = 4
) (
    input  logic [NUM_INPUTS-1:0]         req_i,
    input  logic [$clog2(NUM_INPUTS)-1:0] last_grant_i,
    output logic                          grant_valid_o,
    output logic [$clog2(NUM_INPUTS)-1:0] grant_idx_o
);

    localparam int IDX_W = $clog2(NUM_INPUTS);

    logic [IDX_W-1:0] cand;

    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment; a path that skips an assignment infers a latch.
    always_comb begin
        grant_valid_o = 1'b0;
        grant_idx_o   = '0;
        cand          = '0;
        // Offset NUM_INPUTS lands back on last_grant_i itself, so a lone
        // requester that was also the last winner is still found.
        for (int off = 1; off <= NUM_INPUTS; off++) begin
            cand = IDX_W'(wrap_index(int'(last_grant_i), off, NUM_INPUTS));
            if (!grant_valid_o && req_i[cand]) begin
                grant_valid_o = 1'b1;
                grant_idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/axi_strobed_arbiter.sv
// ---------------------------------------------------------------------------
// axi_strobed_arbiter
//   Rate-paced packet arbiter: a rate counter opens one strobe slot every
//   out_rate enabled cycles; each slot moves at most one beat from one of
//   NUM_INPUTS AXI-Stream inputs to a registered strobed output. Packets are
//   never interleaved: after a non-last beat the winning channel is locked
//   until its last beat, and a locked slot with no beat ready is reported as
//   an underrun.
//   Ports:
//     clk, reset (async, active-high), clear (sync)   clock / resets
//     enable        in   allow slots to be generated
//     out_rate      in   CNT_W  cycles per slot (0 and 1 mean every cycle)
//     i_tdata       in   NUM_INPUTS*WIDTH, channel 0 in the LSBs
//     i_tlast/valid in   NUM_INPUTS
//     i_tready      out  NUM_INPUTS, one-hot or zero, only in slot cycles
//     out_stb/last  out  beat strobe and end-of-packet, one cycle after slot
//     out_data      out  WIDTH;  out_chan out source channel
//     error         out  one-cycle underrun pulse; underrun_cnt out 16-bit sat
// ---------------------------------------------------------------------------
module axi_strobed_arbiter
    import axi_strobed_arbiter_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int NUM_INPUTS = 4,
    parameter int MIN_RATE   = 256
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          clear,
    input  logic                          enable,
    input  logic [$clog2(MIN_RATE):0]     out_rate,
    input  logic [NUM_INPUTS*WIDTH-1:0]   i_tdata,
    input  logic [NUM_INPUTS-1:0]         i_tlast,
    input  logic [NUM_INPUTS-1:0]         i_tvalid,
    output logic [NUM_INPUTS-1:0]         i_tready,
    output logic                          out_stb,
    output logic                          out_last,
    output logic [WIDTH-1:0]              out_data,
    output logic [$clog2(NUM_INPUTS)-1:0] out_chan,
    output logic                          error,
    output logic [15:0]                   underrun_cnt
);

    localparam int CNT_W = $clog2(MIN_RATE) + 1;
    localparam int CH_W  = $clog2(NUM_INPUTS);
    localparam logic [CH_W-1:0] LAST_GRANT_INIT = CH_W'(NUM_INPUTS - 1);

    // Registered state
    logic [CNT_W-1:0] cnt_q,          cnt_d;
    lock_state_e      lock_q,         lock_d;
    logic [CH_W-1:0]  last_grant_q,   last_grant_d;
    logic             out_stb_q,      out_stb_d;
    logic             out_last_q,     out_last_d;
    logic [WIDTH-1:0] out_data_q,     out_data_d;
    logic [CH_W-1:0]  out_chan_q,     out_chan_d;
    logic             error_q,        error_d;
    logic [15:0]      underrun_cnt_q, underrun_cnt_d;

    // Slot decision
    logic             tick;
    logic             rr_valid;
    logic [CH_W-1:0]  rr_idx;
    logic [CH_W-1:0]  grant_idx;
    slot_kind_e       slot;

    // ">=" rather than "==" so a lowered out_rate (or 0) fires at once
    // instead of waiting for the counter to wrap.
    assign tick = enable && (cnt_q >= out_rate);

    axi_rr_select #(
        .NUM_INPUTS    (NUM_INPUTS)
    ) u_rr_select (
        .req_i         (i_tvalid),
        .last_grant_i  (last_grant_q),
        .grant_valid_o (rr_valid),
        .grant_idx_o   (rr_idx)
    );

    // While locked, last_grant_q is by construction the locked channel (it
    // only changes on a transfer, and only that channel can transfer), so no
    // separate lock-channel register is kept.
    always_comb begin
        slot      = SLOT_NONE;
        grant_idx = rr_idx;
        if (lock_q == LOCK_HELD) begin
            grant_idx = last_grant_q;
        end
        // Slots are suppressed during reset/clear so no source sees a
        // handshake for a beat that would be thrown away.
        if (tick && !reset && !clear) begin
            if (lock_q == LOCK_HELD) begin
                slot = i_tvalid[last_grant_q] ? SLOT_XFER : SLOT_UNDERRUN;
            end else begin
                slot = rr_valid ? SLOT_XFER : SLOT_IDLE;
            end
        end
    end

    always_comb begin
        i_tready = '0;
        if (slot == SLOT_XFER) begin
            i_tready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        cnt_d          = cnt_q;
        lock_d         = lock_q;
        last_grant_d   = last_grant_q;
        out_stb_d      = (slot == SLOT_XFER);
        out_last_d     = out_last_q;
        out_data_d     = out_data_q;
        out_chan_d     = out_chan_q;
        error_d        = (slot == SLOT_UNDERRUN);
        underrun_cnt_d = underrun_cnt_q;

        if (enable) begin
            cnt_d = tick ? CNT_W'(1) : cnt_q + CNT_W'(1);
        end

        if (slot == SLOT_XFER) begin
            out_data_d   = i_tdata[int'(grant_idx)*WIDTH +: WIDTH];
            out_last_d   = i_tlast[grant_idx];
            out_chan_d   = grant_idx;
            last_grant_d = grant_idx;
            lock_d       = i_tlast[grant_idx] ? LOCK_OPEN : LOCK_HELD;
        end

        if (slot == SLOT_UNDERRUN) begin
            underrun_cnt_d = sat_inc16(underrun_cnt_q);
        end

        // Synchronous clear wins over everything and abandons any open packet.
        if (clear) begin
            cnt_d          = CNT_W'(1);
            lock_d         = LOCK_OPEN;
            last_grant_d   = LAST_GRANT_INIT;
            out_stb_d      = 1'b0;
            out_last_d     = 1'b0;
            out_data_d     = '0;
            out_chan_d     = '0;
            error_d        = 1'b0;
            underrun_cnt_d = '0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of every other flop, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q          <= CNT_W'(1);
            lock_q         <= LOCK_OPEN;
            last_grant_q   <= LAST_GRANT_INIT;
            out_stb_q      <= 1'b0;
            out_last_q     <= 1'b0;
            out_data_q     <= '0;
            out_chan_q     <= '0;
            error_q        <= 1'b0;
            underrun_cnt_q <= '0;
        end else begin
            cnt_q          <= cnt_d;
            lock_q         <= lock_d;
            last_grant_q   <= last_grant_d;
            out_stb_q      <= out_stb_d;
            out_last_q     <= out_last_d;
            out_data_q     <= out_data_d;
            out_chan_q     <= out_chan_d;
            error_q        <= error_d;
            underrun_cnt_q <= underrun_cnt_d;
        end
    end

    assign out_stb      = out_stb_q;
    assign out_last     = out_last_q;
    assign out_data     = out_data_q;
    assign out_chan     = out_chan_q;
    assign error        = error_q;
    assign underrun_cnt = underrun_cnt_q;

endmodule

// File: doc/axi_strobed_arbiter.md
AXI_STROBED_ARBITER -- requirements
Module: axi_strobed_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, the data width of each input stream and of out_data.
REQ-002 The block SHALL have parameter NUM_INPUTS, default 4, the number of requesting AXI-Stream inputs (2..16).
REQ-003 The block SHALL have parameter MIN_RATE, default 256, sizing the rate counter; CNT_W = $clog2(MIN_RATE)+1.
REQ-004 clk  input  1  sole clock; all logic on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 clear  input  1  synchronous clear, same effect as reset.
REQ-007 enable  input  1  permits strobe generation.
REQ-008 out_rate  input  CNT_W  clock cycles between strobe slots.
REQ-009 i_tdata  input  NUM_INPUTS*WIDTH  packed input data, channel 0 in the LSBs.
REQ-010 i_tlast, i_tvalid  input  NUM_INPUTS each  per-channel last and valid.
REQ-011 i_tready  output  NUM_INPUTS  per-channel ready.
REQ-012 out_stb, out_last  output  1 each  output strobe and end-of-packet.
REQ-013 out_data  output  WIDTH  strobed data; out_chan  output  $clog2(NUM_INPUTS)  source channel.
REQ-014 error  output  1  one-cycle pulse on mid-packet underrun; underrun_cnt  output  16  saturating underrun count.

Function
REQ-015 Rate counter SHALL reset to 1 and, while enable=1, produce a one-cycle internal slot tick when counter >= out_rate, reloading to 1; otherwise it SHALL increment.
REQ-016 out_rate of 0 or 1 SHALL yield a tick every enabled cycle; a changed out_rate SHALL take effect at the next compare.
REQ-017 While enable=0, the counter SHALL hold, no ticks SHALL occur, and lock state SHALL be retained.
REQ-018 The i_tready bit of at most one channel SHALL be high, only in a tick cycle, and only for the granted channel; i_tready SHALL be combinational from registered state and i_tvalid.
REQ-019 Unlocked tick: grant SHALL go to the first channel with i_tvalid=1, searching round-robin from last_grant+1 (mod NUM_INPUTS); after reset, last_grant = NUM_INPUTS-1.
REQ-020 A granted beat with i_tlast=0 SHALL set lock to that channel; a beat with i_tlast=1 SHALL clear lock.
REQ-021 Locked tick: only the locked channel SHALL be eligible; if its i_tvalid=0, no transfer SHALL occur, error SHALL pulse, and lock SHALL be kept.
REQ-022 Unlocked tick with no valid channel SHALL be an idle slot: no transfer and no error.
REQ-023 Each transferred beat SHALL appear on out_stb, out_data, out_last and out_chan exactly one cycle after the tick, for one cycle.
REQ-024 error SHALL likewise be registered, one cycle after the tick; out_stb and error SHALL never both be high.
REQ-025 underrun_cnt SHALL increment on each error and saturate at 16'hFFFF.
REQ-026 last_grant SHALL update only on a transfer.

Reset
REQ-027 reset (async) or clear (sync) SHALL set counter=1, lock cleared, last_grant=NUM_INPUTS-1, out_stb=0, out_last=0, out_data=0, out_chan=0, error=0, underrun_cnt=0.
REQ-028 Reset or clear during a locked packet SHALL abandon the packet; the next tick after release SHALL arbitrate unlocked.
REQ-029 i_tready SHALL be all-zero while reset is asserted.

Structure
REQ-030 No shared package is required; CNT_W and the channel-index width SHALL be local parameters.
REQ-031 The round-robin search SHALL be a sub-module, axi_rr_select (inputs request vector and last_grant; outputs grant_valid and grant index), purely combinational.

Verification
REQ-032 out_rate=4, enable=1, ch0 continuously valid with single-beat packets -> out_stb pulses every 4 cycles; ticks occur at cycles 4, 8, 12... after reset release.
REQ-033 All 4 channels valid with single-beat packets, out_rate=1 -> out_chan sequence 0,1,2,3,0... on consecutive cycles.
REQ-034 ch1 sends a 3-beat packet while ch2 is valid -> out_chan 1,1,1 then 2; ch2 i_tready stays 0 during the lock.
REQ-035 ch1 locked after beat 1, i_tvalid deasserted for 2 ticks -> error pulses twice, underrun_cnt=2, the next beat comes from ch1.
REQ-036 No channel valid for 10 ticks -> no out_stb, no error, underrun_cnt unchanged.
REQ-037 Async reset asserted mid-packet between clock edges -> outputs zero immediately, and after release the first beat is granted by round-robin starting at ch0.
